// File: rtl/rupt_controller.sv
// rupt_controller
// Interrupt sequencer. On an instruction boundary with interrupts enabled,
// no accumulator overflow and at least one pending flag, it latches the
// highest-priority source together with Z, BB (and optionally A), acquires
// the memory bus, stores the context into the register map, writes the
// vector into Z (o5), pulses rupt_taken and the matching interrupt_clear
// bit, then holds in_rupt until the CPU executes RESUME. No nesting.
//
// Optional feature macro: RUPT_SAVE_A_EN -- adds the SAVE_A state that
// stores the accumulator to o10 before Z (ARUPT); otherwise ARUPT is left
// to software.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   interrupt_flags[5:0]       pending flags (bit3 T6, bit2 T5, bit0 T3,
//                              bit1 T4, bit4 KEYRUPT1, bit5 KEYRUPT2)
//   interrupt_enable           global enable (RELINT=1 / INHINT=0)
//   inst_boundary              CPU may be preempted this cycle
//   resume                     one-cycle pulse on RESUME
//   z_in, bb_in, a_in          CPU context to save
//   bus_req / bus_gnt          memory bus handshake
//   mem_address, mem_data,
//   mem_bus_enable,
//   mem_write_enable           write port into the register/erasable map
//   interrupt_clear[5:0]       one-hot clear pulse for the serviced flag
//   rupt_taken                 CPU aborts its fetch and refetches from Z
//   in_rupt, rupt_source[2:0]  ISR active / index of serviced flag
module rupt_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  interrupt_flags,
  input  logic        interrupt_enable,
  input  logic        inst_boundary,
  input  logic        resume,
  input  logic [11:0] z_in,
  input  logic [15:0] bb_in,
  input  logic [15:0] a_in,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [11:0] mem_address,
  output logic [15:0] mem_data,
  output logic        mem_bus_enable,
  output logic        mem_write_enable,
  output logic [5:0]  interrupt_clear,
  output logic        rupt_taken,
  output logic        in_rupt,
  output logic [2:0]  rupt_source
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
`ifdef RUPT_SAVE_A_EN
    SAVE_A = 3'd2,
`endif
    SAVE_Z = 3'd3,
    SAVE_B = 3'd4,
    VECTOR = 3'd5,
    ACTIVE = 3'd6
  } state_t;

  localparam logic [11:0] ADDR_A = 12'o10;
  localparam logic [11:0] ADDR_Z = 12'o5;
  localparam logic [11:0] ADDR_ZRUPT = 12'o15;
  localparam logic [11:0] ADDR_BRUPT = 12'o17;

  state_t      state_q, state_d;
  logic [2:0]  src_q, src_d;
  logic [11:0] vec_q, vec_d;
  logic [11:0] z_q, z_d;
  logic [15:0] bb_q, bb_d;
`ifdef RUPT_SAVE_A_EN
  logic [15:0] a_q, a_d;
`else
  logic        unused_a_bits;
  assign unused_a_bits = ^a_in[13:0];
`endif

  logic [2:0]  win_src;
  logic [11:0] win_vec;
  logic        take;

  // Fixed priority: T6 > T5 > T3 > T4 > KEYRUPT1 > KEYRUPT2.
  always_comb begin
    win_src = '0;
    win_vec = '0;
    if (interrupt_flags[3]) begin
      win_src = 3'd3; win_vec = 12'o4004;
    end else if (interrupt_flags[2]) begin
      win_src = 3'd2; win_vec = 12'o4010;
    end else if (interrupt_flags[0]) begin
      win_src = 3'd0; win_vec = 12'o4014;
    end else if (interrupt_flags[1]) begin
      win_src = 3'd1; win_vec = 12'o4020;
    end else if (interrupt_flags[4]) begin
      win_src = 3'd4; win_vec = 12'o4024;
    end else if (interrupt_flags[5]) begin
      win_src = 3'd5; win_vec = 12'o4030;
    end
  end

  // An overflowed accumulator (a_in[15] != a_in[14]) blocks the interrupt.
  assign take = inst_boundary && interrupt_enable && (|interrupt_flags)
                && (a_in[15] == a_in[14]);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    vec_d   = vec_q;
    z_d     = z_q;
    bb_d    = bb_q;
`ifdef RUPT_SAVE_A_EN
    a_d     = a_q;
`endif
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = REQ;
          src_d   = win_src;
          vec_d   = win_vec;
          z_d     = z_in;
          bb_d    = bb_in;
`ifdef RUPT_SAVE_A_EN
          a_d     = a_in;
`endif
        end
      end
      REQ: begin
        if (bus_gnt) begin
`ifdef RUPT_SAVE_A_EN
          state_d = SAVE_A;
`else
          state_d = SAVE_Z;
`endif
        end
      end
`ifdef RUPT_SAVE_A_EN
      SAVE_A: if (bus_gnt) state_d = SAVE_Z;
`endif
      SAVE_Z: if (bus_gnt) state_d = SAVE_B;
      SAVE_B: if (bus_gnt) state_d = VECTOR;
      VECTOR: if (bus_gnt) state_d = ACTIVE;
      ACTIVE: if (resume) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      vec_q   <= '0;
      z_q     <= '0;
      bb_q    <= '0;
`ifdef RUPT_SAVE_A_EN
      a_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      vec_q   <= vec_d;
      z_q     <= z_d;
      bb_q    <= bb_d;
`ifdef RUPT_SAVE_A_EN
      a_q     <= a_d;
`endif
    end
  end

  // Outputs decode from the registered state. The write strobes follow
  // bus_gnt in the same cycle so a withdrawn grant stalls without writing,
  // while address/data stay stable. Reset forces every output low at once.
  always_comb begin
    bus_req          = 1'b0;
    mem_address      = '0;
    mem_data         = '0;
    mem_bus_enable   = 1'b0;
    mem_write_enable = 1'b0;
    interrupt_clear  = '0;
    rupt_taken       = 1'b0;
    in_rupt          = 1'b0;
    rupt_source      = '0;
    if (!reset) begin
      rupt_source = src_q;
      case (state_q)
        REQ: bus_req = 1'b1;
`ifdef RUPT_SAVE_A_EN
        SAVE_A: begin
          bus_req        = 1'b1;
          mem_address    = ADDR_A;
          mem_data       = a_q;
          mem_bus_enable = bus_gnt;
        end
`endif
        SAVE_Z: begin
          bus_req        = 1'b1;
          mem_address    = ADDR_ZRUPT;
          mem_data       = {4'b0, z_q};
          mem_bus_enable = bus_gnt;
        end
        SAVE_B: begin
          bus_req        = 1'b1;
          mem_address    = ADDR_BRUPT;
          mem_data       = bb_q;
          mem_bus_enable = bus_gnt;
        end
        VECTOR: begin
          bus_req         = 1'b1;
          mem_address     = ADDR_Z;
          mem_data        = {4'b0, vec_q};
          mem_bus_enable  = bus_gnt;
          rupt_taken      = bus_gnt;
          interrupt_clear = bus_gnt ? (6'b1 << src_q) : '0;
        end
        ACTIVE: in_rupt = 1'b1;
        default: ;
      endcase
      mem_write_enable = mem_bus_enable;
    end
  end

endmodule

// File: doc/rupt_controller.md
RUPT_CONTROLLER -- requirements
Module: rupt_controller

Interface
REQ-001 The block SHALL have these ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 interrupt_flags  in  6  pending flags: bit3 T6, bit2 T5, bit0 T3, bit1 T4, bit4 KEYRUPT1, bit5 KEYRUPT2.
REQ-004 interrupt_enable  in  1  global enable (RELINT=1, INHINT=0).
REQ-005 inst_boundary  in  1  CPU is at an instruction fetch point and may be preempted this cycle.
REQ-006 resume  in  1  one-cycle pulse when the CPU executes RESUME.
REQ-007 z_in  in  12  current program counter; bb_in  in  16  both-bank value; a_in  in  16  accumulator.
REQ-008 bus_req  out  1  memory bus request; bus_gnt  in  1  memory bus grant.
REQ-009 mem_address  out  12; mem_data  out  16; mem_bus_enable  out  1; mem_write_enable  out  1: write port into the register/erasable map.
REQ-010 interrupt_clear  out  6  one-hot, one-cycle clear pulse to the timer/flag logic.
REQ-011 rupt_taken  out  1  one-cycle pulse: CPU shall abort its fetch and refetch from the new Z.
REQ-012 in_rupt  out  1  high while an ISR is active; rupt_source  out  3  encoded index of the serviced flag.

Function
REQ-013 States SHALL be IDLE, REQ, SAVE_A (macro only), SAVE_Z, SAVE_B, VECTOR, ACTIVE.
REQ-014 IDLE->REQ SHALL occur when inst_boundary=1, interrupt_enable=1, any flag set, and a_in[15]==a_in[14] (no overflow).
REQ-015 Priority SHALL be bit3 > bit2 > bit0 > bit1 > bit4 > bit5. The winner and its vector (o4004, o4010, o4014, o4020, o4024, o4030 respectively) SHALL be latched on the IDLE->REQ transition. z_in, bb_in and a_in SHALL be latched at the same time.
REQ-016 In REQ, bus_req SHALL be 1. When bus_gnt=1 the next state SHALL be SAVE_A (macro) or SAVE_Z.
REQ-017 bus_req SHALL stay 1 from REQ through VECTOR inclusive and be 0 in all other states.
REQ-018 In each write state with bus_gnt=1:
- mem_bus_enable and mem_write_enable SHALL both be 1.
- The FSM SHALL advance one state per cycle.
- SAVE_A writes o10 with latched A; SAVE_Z writes o15 with {4'b0, latched Z}; SAVE_B writes o17 with latched BB; VECTOR writes o5 with the vector.
REQ-019 In a write state with bus_gnt=0, mem_bus_enable SHALL be 0, the state SHALL be held, and address/data SHALL be held.
REQ-020 The VECTOR write cycle SHALL also assert rupt_taken and interrupt_clear[winner] for one cycle, then go to ACTIVE.
REQ-021 In ACTIVE, in_rupt SHALL be 1 and no new interrupt SHALL be taken (no nesting). resume SHALL return to IDLE. resume in any other state SHALL be ignored.
REQ-022 A flag deasserting after latching SHALL NOT abort the sequence. The latched source SHALL still be vectored and cleared.
REQ-023 resume and a pending flag in the same cycle: go to IDLE, and the pending flag SHALL be evaluated at the next inst_boundary, no earlier than the following cycle.
REQ-024 Minimum latency with bus_gnt held high and no macro: detect cycle T, REQ T+1, SAVE_Z T+2, SAVE_B T+3, VECTOR T+4.

Reset
REQ-025 While reset=1:
- The state SHALL be IDLE.
- bus_req, mem_bus_enable, mem_write_enable, interrupt_clear, rupt_taken, in_rupt, rupt_source, mem_address and mem_data SHALL all be 0.
REQ-026 Reset mid-sequence SHALL abandon the sequence with no further writes and no clear pulse.

Configuration
REQ-027 With RUPT_SAVE_A_EN defined, the SAVE_A state SHALL exist, REQ SHALL go to SAVE_A, and minimum latency SHALL be 5 cycles.
REQ-028 Without RUPT_SAVE_A_EN, SAVE_A SHALL be absent, REQ SHALL go to SAVE_Z, and ARUPT SHALL be left to software.

Verification
REQ-029 Flags=6'b001001, enable=1, boundary=1, z_in=o4123, bb_in=h0C05, gnt=1 -> writes o15=o4123, o17=h0C05, o5=o4004 at T+2..T+4. At T+4: clear=6'b001000, rupt_taken=1, rupt_source=3.
REQ-030 Same stimulus with a_in=h4000 (overflow) or enable=0 -> no bus_req; state stays IDLE.
REQ-031 bus_gnt low for 3 cycles during SAVE_B -> address o17 and data held, mem_bus_enable=0, no extra writes; VECTOR completes after gnt returns.
REQ-032 In ACTIVE, flag bit1 set and boundary pulses -> nothing taken. resume -> IDLE; next boundary -> vector o4020, clear bit1.
REQ-033 reset asserted in SAVE_Z -> next cycle all outputs 0, no VECTOR write, flag not cleared.
REQ-034 RUPT_SAVE_A_EN defined, a_in=h1234 -> o10=h1234 written at T+2, vector at T+5.
